cpu_bus_controller: RTL and testbench

Services the 6502 core's memory bus: decodes each CPU address, reads/writes the 2 KiB internal work RAM (mirrored), fetches cartridge PRG bytes over a request/acknowledge port, and returns open-bus for unmapped regions. It sits directly downstream of `cpu`:
- it consumes the core's `address_o`, `address_valid_o`, `data_o` and `data_valid_o`;
- it produces the core's `data_i` and `data_valid_i`.

---
 rtl/cpu_bus_pkg.sv | 34 +++
 rtl/cpu_bus_controller_if.sv | 45 ++++
 rtl/work_ram.sv | 25 ++
 rtl/cpu_bus_controller.sv | 158 +++++++++++++++
 tb/tb_cpu_bus_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and address-map constants for the CPU bus controller.
// The region decode function is the single source of truth for the memory map.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAM_WAIT  = 2'd1,
        CART_WAIT = 2'd2,
        READY     = 2'd3
    } bus_state_t;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_CART = 2'd1,
        REGION_OPEN = 2'd2
    } bus_region_t;

    localparam logic [15:0] RAM_REGION_LAST   = 16'h1FFF;
    localparam logic [15:0] CART_REGION_FIRST = 16'h8000;
    localparam int          CART_ADDR_WIDTH   = 15;

    function automatic bus_region_t decode_region(input logic [15:0] addr);
        bus_region_t region;
        if (addr <= RAM_REGION_LAST) begin
            region = REGION_RAM;
        end else if (addr >= CART_REGION_FIRST) begin
            region = REGION_CART;
        end else begin
            region = REGION_OPEN;
        end
        return region;
    endfunction

endpackage

// File: rtl/cpu_bus_controller_if.sv
// CPU-side and cartridge-side bus signals of the controller.
// Suffixes are from the controller's point of view (slave modport).
interface cpu_bus_controller_if;

    logic [15:0]                             cpu_address_i;
    logic                                    cpu_address_valid_i;
    logic [7:0]                              cpu_data_i;
    logic                                    cpu_write_i;
    logic [7:0]                              cpu_data_o;
    logic                                    cpu_data_valid_o;
    logic                                    cart_req_o;
    logic [cpu_bus_pkg::CART_ADDR_WIDTH-1:0] cart_address_o;
    logic [7:0]                              cart_data_i;
    logic                                    cart_ack_i;
    logic                                    cart_timeout_o;

    modport slave (
        input  cpu_address_i,
        input  cpu_address_valid_i,
        input  cpu_data_i,
        input  cpu_write_i,
        output cpu_data_o,
        output cpu_data_valid_o,
        output cart_req_o,
        output cart_address_o,
        input  cart_data_i,
        input  cart_ack_i,
        output cart_timeout_o
    );

    modport master (
        output cpu_address_i,
        output cpu_address_valid_i,
        output cpu_data_i,
        output cpu_write_i,
        input  cpu_data_o,
        input  cpu_data_valid_o,
        input  cart_req_o,
        input  cart_address_o,
        output cart_data_i,
        output cart_ack_i,
        input  cart_timeout_o
    );

endinterface

// File: rtl/work_ram.sv
// Single-port synchronous work RAM, one access per cycle, 1-cycle read latency.
// Contents are deliberately not reset so the array maps onto block RAM.
module work_ram #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            wdata_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem_q [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_controller.sv
// Decodes CPU bus cycles into work-RAM accesses, cartridge PRG fetches or open-bus
// returns, and presents the read byte with a valid flag until the address moves.
module cpu_bus_controller
    import cpu_bus_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 11,
    parameter int CART_TIMEOUT   = 255
) (
    input  logic           clock_i,
    input  logic           reset_i,
    cpu_bus_controller_if.slave bus
);

    localparam int CNT_W = (CART_TIMEOUT > 1) ? $clog2(CART_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CART_TIMEOUT - 1);

    bus_state_t                 state_q, state_d;
    logic [7:0]                 cpu_data_q, cpu_data_d;
    logic                       cpu_data_valid_q, cpu_data_valid_d;
    logic                       cart_req_q, cart_req_d;
    logic [CART_ADDR_WIDTH-1:0] cart_address_q, cart_address_d;
    logic                       cart_timeout_q, cart_timeout_d;
    logic [7:0]                 open_bus_q, open_bus_d;
    logic [15:0]                served_address_q, served_address_d;
    logic [CNT_W-1:0]           timeout_cnt_q, timeout_cnt_d;

    bus_region_t region;
    logic        read_req;
    logic        write_cycle;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    assign region      = decode_region(bus.cpu_address_i);
    assign read_req    = bus.cpu_address_valid_i && !bus.cpu_write_i;
    assign write_cycle = bus.cpu_address_valid_i && bus.cpu_write_i;
    assign ram_we      = write_cycle && (region == REGION_RAM);

    // The RAM address follows the CPU address every cycle, so the read issued on
    // the request edge is ready to capture in RAM_WAIT.
    work_ram #(
        .ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_work_ram (
        .clock_i (clock_i),
        .we_i    (ram_we),
        .addr_i  (bus.cpu_address_i[RAM_ADDR_WIDTH-1:0]),
        .wdata_i (bus.cpu_data_i),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d          = state_q;
        cpu_data_d       = cpu_data_q;
        cpu_data_valid_d = 1'b0;
        cart_req_d       = cart_req_q;
        cart_address_d   = cart_address_q;
        cart_timeout_d   = cart_timeout_q;
        open_bus_d       = open_bus_q;
        served_address_d = served_address_q;
        timeout_cnt_d    = timeout_cnt_q;

        if (write_cycle) begin
            open_bus_d = bus.cpu_data_i;
        end

        unique case (state_q)
            IDLE: begin
                if (read_req) begin
                    served_address_d = bus.cpu_address_i;
                    unique case (region)
                        REGION_RAM: begin
                            state_d = RAM_WAIT;
                        end
                        REGION_CART: begin
                            cart_req_d     = 1'b1;
                            cart_address_d = bus.cpu_address_i[CART_ADDR_WIDTH-1:0];
                            timeout_cnt_d  = '0;
                            state_d        = CART_WAIT;
                        end
                        default: begin
                            cpu_data_d = open_bus_q;
                            state_d    = READY;
                        end
                    endcase
                end
            end

            RAM_WAIT: begin
                if (write_cycle) begin
                    state_d = IDLE;
                end else begin
                    cpu_data_d = ram_rdata;
                    open_bus_d = ram_rdata;
                    state_d    = READY;
                end
            end

            // Ack is tested first so an ack on the expiry edge still delivers data.
            CART_WAIT: begin
                if (bus.cart_ack_i) begin
                    cpu_data_d = bus.cart_data_i;
                    open_bus_d = bus.cart_data_i;
                    cart_req_d = 1'b0;
                    state_d    = READY;
                end else if (timeout_cnt_q == CNT_LAST) begin
                    cpu_data_d     = open_bus_q;
                    cart_req_d     = 1'b0;
                    cart_timeout_d = 1'b1;
                    state_d        = READY;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                end
            end

            READY: begin
                if (read_req && (bus.cpu_address_i == served_address_q)) begin
                    cpu_data_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            cpu_data_q       <= 8'h00;
            cpu_data_valid_q <= 1'b0;
            cart_req_q       <= 1'b0;
            cart_address_q   <= '0;
            cart_timeout_q   <= 1'b0;
            open_bus_q       <= 8'h00;
            served_address_q <= 16'h0000;
            timeout_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            cpu_data_q       <= cpu_data_d;
            cpu_data_valid_q <= cpu_data_valid_d;
            cart_req_q       <= cart_req_d;
            cart_address_q   <= cart_address_d;
            cart_timeout_q   <= cart_timeout_d;
            open_bus_q       <= open_bus_d;
            served_address_q <= served_address_d;
            timeout_cnt_q    <= timeout_cnt_d;
        end
    end

    assign bus.cpu_data_o       = cpu_data_q;
    assign bus.cpu_data_valid_o = cpu_data_valid_q;
    assign bus.cart_req_o       = cart_req_q;
    assign bus.cart_address_o   = cart_address_q;
    assign bus.cart_timeout_o   = cart_timeout_q;

endmodule

// File: tb/tb_cpu_bus_controller.sv
// Directed plus randomized checks of cpu_bus_controller against a memory-map
// model: RAM array with mirroring, open-bus byte and sticky timeout flag.
module tb_cpu_bus_controller;

    localparam int T = 24;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram_m [0:2047];
    logic [7:0]  open_m;
    logic        timeout_m;
    logic [10:0] pool [0:7];

    cpu_bus_controller_if bus ();

    cpu_bus_controller #(
        .RAM_ADDR_WIDTH (11),
        .CART_TIMEOUT   (T)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int exp_lat, input logic [7:0] exp_data, input string tag);
        int lat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.cpu_data_valid_o && lat < 8);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, bus.cpu_data_o, exp_data);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        bus.cpu_address_i       = addr;
        bus.cpu_address_valid_i = 1'b1;
        bus.cpu_write_i         = 1'b1;
        bus.cpu_data_i          = data;
        if (addr <= 16'h1FFF) ram_m[addr[10:0]] = data;
        open_m = data;
        tick();
        bus.cpu_write_i         = 1'b0;
        bus.cpu_address_valid_i = 1'b0;
        check($sformatf("wr_%04h_valid_low", addr), bus.cpu_data_valid_o, 0);
        $display("write addr=%04h data=%02h", addr, data);
    endtask

    // ack_k: edge after the request edge on which ack is sampled (>T means never)
    task automatic do_read(input logic [15:0] addr, input int ack_k,
                           input logic [7:0] cdata, input bit keep);
        logic [7:0] exp_data;
        bit         done;
        bus.cpu_address_i       = addr;
        bus.cpu_address_valid_i = 1'b1;
        bus.cpu_write_i         = 1'b0;
        if (addr <= 16'h1FFF) begin
            exp_data = ram_m[addr[10:0]];
            open_m   = exp_data;
            wait_valid(3, exp_data, $sformatf("ram_%04h", addr));
        end else if (addr >= 16'h8000) begin
            tick();
            check("cart_req_rise", bus.cart_req_o, 1);
            check("cart_addr", bus.cart_address_o, {17'd0, addr[14:0]});
            done     = 1'b0;
            exp_data = 8'h00;
            for (int k = 1; k <= T && !done; k++) begin
                if (k == ack_k) begin
                    bus.cart_ack_i  = 1'b1;
                    bus.cart_data_i = cdata;
                end
                tick();
                bus.cart_ack_i = 1'b0;
                if (k == ack_k) begin
                    exp_data = cdata;
                    open_m   = cdata;
                    check("cart_req_drop_ack", bus.cart_req_o, 0);
                    check("cart_valid_wait", bus.cpu_data_valid_o, 0);
                    done = 1'b1;
                end else if (k == T) begin
                    exp_data  = open_m;
                    timeout_m = 1'b1;
                    check("cart_req_drop_timeout", bus.cart_req_o, 0);
                    check("cart_timeout_set", bus.cart_timeout_o, 1);
                    done = 1'b1;
                end else if (k == 1 || k == T - 1) begin
                    check("cart_req_hold", bus.cart_req_o, 1);
                end
            end
            tick();
            check($sformatf("cart_%04h_valid", addr), bus.cpu_data_valid_o, 1);
            check($sformatf("cart_%04h_data", addr), bus.cpu_data_o, exp_data);
            check("cart_timeout_flag", bus.cart_timeout_o, timeout_m);
        end else begin
            exp_data = open_m;
            wait_valid(2, exp_data, $sformatf("open_%04h", addr));
        end
        $display("read  addr=%04h data=%02h expected=%02h ack_k=%0d", addr, bus.cpu_data_o, exp_data, ack_k);
        if (!keep) begin
            bus.cpu_address_valid_i = 1'b0;
            tick();
            check("valid_clear", bus.cpu_data_valid_o, 0);
        end
    endtask

    function automatic logic [15:0] ram_alias(input logic [10:0] base, input int mirror);
        return 16'({5'd0, base}) + 16'(mirror) * 16'h0800;
    endfunction

    int          op;
    logic [15:0] a;
    logic [7:0]  d;

    initial begin
        rst                     = 1'b1;
        bus.cpu_address_i       = 16'h0000;
        bus.cpu_address_valid_i = 1'b0;
        bus.cpu_data_i          = 8'h00;
        bus.cpu_write_i         = 1'b0;
        bus.cart_data_i         = 8'h00;
        bus.cart_ack_i          = 1'b0;
        open_m                  = 8'h00;
        timeout_m               = 1'b0;

        tick();
        tick();
        check("rst_data", bus.cpu_data_o, 0);
        check("rst_valid", bus.cpu_data_valid_o, 0);
        check("rst_req", bus.cart_req_o, 0);
        check("rst_cart_addr", bus.cart_address_o, 0);
        check("rst_timeout", bus.cart_timeout_o, 0);
        #2 rst = 1'b0;
        tick();

        do_read(16'hFFFC, 3, 8'h34, 1'b0);

        do_write(16'h0012, 8'h5A);
        do_read(16'h0812, 0, 8'h00, 1'b0);
        do_read(16'h0012, 0, 8'h00, 1'b0);

        // Write into a READY read of the same address, then read straight back
        do_write(16'h0100, 8'h11);
        do_read(16'h0100, 0, 8'h00, 1'b1);
        bus.cpu_write_i = 1'b1;
        bus.cpu_data_i  = 8'hAA;
        ram_m[11'h100]  = 8'hAA;
        open_m          = 8'hAA;
        tick();
        check("wr_invalidate_valid", bus.cpu_data_valid_o, 0);
        bus.cpu_write_i = 1'b0;
        wait_valid(3, 8'hAA, "fresh_0100");
        bus.cpu_address_valid_i = 1'b0;
        tick();

        do_write(16'h0300, 8'h7E);
        do_read(16'h4020, 0, 8'h00, 1'b0);
        do_write(16'h9000, 8'h99);
        do_read(16'h0300, 0, 8'h00, 1'b0);
        do_read(16'h1300, 0, 8'h00, 1'b0);

        do_read(16'hA000, T, 8'hC3, 1'b0);
        do_read(16'hB000, T + 1, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a cart fetch
        bus.cpu_address_i       = 16'hC000;
        bus.cpu_address_valid_i = 1'b1;
        tick();
        check("pre_rst_req", bus.cart_req_o, 1);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check("async_rst_req", bus.cart_req_o, 0);
        check("async_rst_valid", bus.cpu_data_valid_o, 0);
        check("async_rst_data", bus.cpu_data_o, 0);
        check("async_rst_timeout", bus.cart_timeout_o, 0);
        bus.cpu_address_valid_i = 1'b0;
        open_m    = 8'h00;
        timeout_m = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        do_read(16'h4020, 0, 8'h00, 1'b0);
        do_read(16'h0012, 0, 8'h00, 1'b0);

        for (int j = 0; j < 8; j++) begin
            pool[j] = 11'($urandom_range(0, 2047));
            do_write(ram_alias(pool[j], 0), 8'($urandom));
        end

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            if (op < 3) begin
                do_write(ram_alias(pool[$urandom_range(0, 7)], $urandom_range(0, 3)), d);
            end else if (op == 3) begin
                a = 16'($urandom_range(16'h2000, 16'hFFFF));
                do_write(a, d);
            end else if (op < 6) begin
                do_read(ram_alias(pool[$urandom_range(0, 7)], $urandom_range(0, 3)), 0, 8'h00, 1'b0);
            end else if (op == 6) begin
                a = 16'($urandom_range(16'h2000, 16'h7FFF));
                do_read(a, 0, 8'h00, 1'b0);
            end else begin
                a = 16'($urandom_range(16'h8000, 16'hFFFF));
                do_read(a, $urandom_range(1, T + 2), d, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
